pipe_ctrl_hazard: RTL and testbench
===================================

// Module: pipe_ctrl_hazard
// PURPOSE
//  Consumer of the opcode decoder's control bundle: carries decoded controls ID->EX->MEM->WB,
//  detects RAW/load-use hazards against in-flight writers, generates IF/ID stall and flush,
//  and inserts bubbles. Sits between the decoder outputs and the EX/MEM/WB datapath muxes.
// PARAMETERS
//  REG_AW     5   register-index width
//  ALUOP_W    3   ALUop width (matches decoder)
// PORTS
//  clk            in   1  rising-edge clock
//  reset          in   1  synchronous, active-high
//  id_valid       in   1  ID holds a real instruction
//  id_regDst,id_jump,id_branch,id_memRead,id_memToReg,id_regWrite,id_ALUSrc,id_memWrite  in 1 each  decoder controls
//  id_ALUop       in   ALUOP_W  decoder ALU op
//  id_rs,id_rt,id_rd  in  REG_AW  ID register fields
//  ex_branch_taken in  1  EX compare result (meaningful only when ex_branch)
//  stall          out  1  hold PC and IF/ID this cycle
//  flush_ifid     out  1  squash IF/ID on next edge
//  ex_valid,ex_branch,ex_ALUSrc,ex_memRead  out 1; ex_ALUop out ALUOP_W; ex_rs,ex_rt out REG_AW
//  mem_valid,mem_memRead,mem_memWrite  out 1
//  wb_valid,wb_regWrite,wb_memToReg  out 1; wb_dest out REG_AW
//  fwd_a,fwd_b    out  2  EX operand select (only with PIPE_CTRL_FWD_EN; else tied 2'b00)
// BEHAVIOUR
//  - Reset: every output and stage register 0 (no X); 0 outputs = bubble.
//  - Latency: id_* captured into EX 1 cycle later, MEM 2, WB 3, absent stall/flush.
//  - dest = id_regDst ? id_rd : id_rt, computed at ID->EX capture; regWrite forced 0 when dest==0.
//  - ID uses rs always; uses rt when (!id_ALUSrc | id_memWrite | id_branch). Only used fields checked.
//  - Hazard (no FWD): valid ID source == nonzero dest of valid regWrite instr in EX or MEM -> stall.
//    Regfile is write-before-read, so WB never causes a stall. Stall may last 2 cycles.
//  - Hazard (FWD): only load-use: ex_memRead & ex_valid & ex dest == used ID source -> stall 1 cycle.
//  - On stall: EX loads bubble (all controls 0, ex_valid 0); MEM/WB advance; id_* held stable by upstream.
//  - Branch: ex_valid & ex_branch & ex_branch_taken -> flush_ifid=1, ID instr replaced by bubble into EX,
//    stall forced 0 that cycle (flush beats stall).
//  - Jump: id_valid & id_jump & !stall -> flush_ifid=1; jump itself proceeds to EX (no writes).
//  - Simultaneous branch-taken in EX and jump in ID: branch wins, jump squashed.
//  - id_valid=0 -> bubble enters EX, no hazard raised.
//  - reset asserted mid-stall or mid-flush: next edge clears all stages; stall/flush_ifid 0 after.
//  - FSM: none beyond stage registers; stall/flush are combinational from stage state + ID inputs.
// CONFIGURATION
//  PIPE_CTRL_FWD_EN defined: forwarding select generated for EX operands rs (fwd_a), rt (fwd_b):
//    2'b10 = MEM-stage result if mem regWrite & dest match; else 2'b01 = WB if wb match; else 2'b00.
//    MEM has priority over WB; dest 0 never matches. Only load-use stalls.
//  Not defined: fwd_a/fwd_b tied 2'b00; full RAW stall rule above applies.
// TESTING
//  1 reset held 2 cycles with id_valid=1 -> all outputs 0; release -> ex_valid=1 next edge.
//  2 add $3,$1,$2 then add $4,$3,$5 (no FWD) -> stall=1 for 2 cycles, two EX bubbles, then issue.
//  3 same pair with FWD_EN -> stall=0, fwd_a=2'b10 in EX of 2nd; with one instr between -> fwd_a=2'b01.
//  4 lw $6,0($1) then add $7,$6,$6 (FWD_EN) -> stall=1 exactly 1 cycle, then fwd_a=fwd_b=2'b01.
//  5 beq in EX with ex_branch_taken=1 while ID holds load-use hazard -> flush_ifid=1, stall=0, EX bubble.
//  6 addi $0,$1,5 followed by add $2,$0,$0 -> wb_regWrite=0, no stall, fwd_a=fwd_b=2'b00.

Source files
------------

// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control carrier ID->EX->MEM->WB with RAW/load-use hazard stall, branch/jump flush.
// Define PIPE_CTRL_FWD_EN to generate EX operand forwarding selects and stall only on load-use.
module pipe_ctrl_hazard #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic               id_regDst,
  input  logic               id_jump,
  input  logic               id_branch,
  input  logic               id_memRead,
  input  logic               id_memToReg,
  input  logic               id_regWrite,
  input  logic               id_ALUSrc,
  input  logic               id_memWrite,
  input  logic [ALUOP_W-1:0] id_ALUop,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush_ifid,
  output logic               ex_valid,
  output logic               ex_branch,
  output logic               ex_ALUSrc,
  output logic               ex_memRead,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic               mem_valid,
  output logic               mem_memRead,
  output logic               mem_memWrite,
  output logic               wb_valid,
  output logic               wb_regWrite,
  output logic               wb_memToReg,
  output logic [REG_AW-1:0]  wb_dest,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  typedef struct packed {
    logic               valid;
    logic               branch;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  dest;
  } ex_stage_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dest;
  } mem_stage_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dest;
  } wb_stage_t;

  ex_stage_t  ex_d, ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d, wb_q;

  logic              use_rs, use_rt;
  logic              branch_taken;
  logic              raw_hazard;
  logic [REG_AW-1:0] id_dest;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  function automatic logic hits(input logic [REG_AW-1:0] src, input logic used,
                                input logic writer, input logic [REG_AW-1:0] dst);
    return used & writer & (dst != '0) & (src == dst);
  endfunction

  always_comb begin
    use_rs       = id_valid;
    use_rt       = id_valid & (~id_ALUSrc | id_memWrite | id_branch);
    branch_taken = ex_q.valid & ex_q.branch & ex_branch_taken;
`ifdef PIPE_CTRL_FWD_EN
    raw_hazard = hits(id_rs, use_rs, ex_q.valid & ex_q.mem_read, ex_q.dest)
               | hits(id_rt, use_rt, ex_q.valid & ex_q.mem_read, ex_q.dest);
`else
    // WB is not checked: the regfile writes before it is read in the same cycle.
    raw_hazard = hits(id_rs, use_rs, ex_q.valid & ex_q.reg_write, ex_q.dest)
               | hits(id_rt, use_rt, ex_q.valid & ex_q.reg_write, ex_q.dest)
               | hits(id_rs, use_rs, mem_q.valid & mem_q.reg_write, mem_q.dest)
               | hits(id_rt, use_rt, mem_q.valid & mem_q.reg_write, mem_q.dest);
`endif
    stall      = raw_hazard & ~branch_taken & ~reset;
    flush_ifid = ~reset & (branch_taken | (id_valid & id_jump & ~stall));
  end

  always_comb begin
    id_dest = id_regDst ? id_rd : id_rt;
    ex_d    = '0;
    if (id_valid && !stall && !branch_taken) begin
      ex_d.valid      = 1'b1;
      ex_d.branch     = id_branch;
      ex_d.alu_src    = id_ALUSrc;
      ex_d.mem_read   = id_memRead;
      ex_d.mem_write  = id_memWrite;
      ex_d.mem_to_reg = id_memToReg;
      ex_d.reg_write  = id_regWrite & ~id_jump & (id_dest != '0);
      ex_d.alu_op     = id_ALUop;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dest       = id_dest;
    end
    mem_d = '{valid:      ex_q.valid,
              mem_read:   ex_q.mem_read,
              mem_write:  ex_q.mem_write,
              mem_to_reg: ex_q.mem_to_reg,
              reg_write:  ex_q.reg_write,
              dest:       ex_q.dest};
    wb_d  = '{valid:      mem_q.valid,
              reg_write:  mem_q.reg_write,
              mem_to_reg: mem_q.mem_to_reg,
              dest:       mem_q.dest};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_branch    = ex_q.branch;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_memRead   = ex_q.mem_read;
  assign ex_ALUop     = ex_q.alu_op;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign mem_valid    = mem_q.valid;
  assign mem_memRead  = mem_q.mem_read;
  assign mem_memWrite = mem_q.mem_write;
  assign wb_valid     = wb_q.valid;
  assign wb_regWrite  = wb_q.reg_write;
  assign wb_memToReg  = wb_q.mem_to_reg;
  assign wb_dest      = wb_q.dest;

`ifdef PIPE_CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (hits(src, 1'b1, mem_q.valid & mem_q.reg_write, mem_q.dest)) begin
      return 2'b10;
    end else if (hits(src, 1'b1, wb_q.valid & wb_q.reg_write, wb_q.dest)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_q.rs);
    fwd_b = fwd_sel(ex_q.rt);
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Self-checking bench for pipe_ctrl_hazard: directed programs plus randomized instruction
// streams, all checked against an instruction-level pipeline model.
module tb_pipe_ctrl_hazard;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               id_valid, id_regDst, id_jump, id_branch, id_memRead;
  logic               id_memToReg, id_regWrite, id_ALUSrc, id_memWrite;
  logic [ALUOP_W-1:0] id_ALUop;
  logic [REG_AW-1:0]  id_rs, id_rt, id_rd;
  logic               ex_branch_taken;
  logic               stall, flush_ifid;
  logic               ex_valid, ex_branch, ex_ALUSrc, ex_memRead;
  logic [ALUOP_W-1:0] ex_ALUop;
  logic [REG_AW-1:0]  ex_rs, ex_rt;
  logic               mem_valid, mem_memRead, mem_memWrite;
  logic               wb_valid, wb_regWrite, wb_memToReg;
  logic [REG_AW-1:0]  wb_dest;
  logic [1:0]         fwd_a, fwd_b;

  pipe_ctrl_hazard #(.REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_regDst(id_regDst), .id_jump(id_jump),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_regWrite(id_regWrite), .id_ALUSrc(id_ALUSrc), .id_memWrite(id_memWrite),
    .id_ALUop(id_ALUop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_ifid(flush_ifid),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_ALUSrc(ex_ALUSrc), .ex_memRead(ex_memRead),
    .ex_ALUop(ex_ALUop), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_valid(mem_valid),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .wb_valid(wb_valid),
    .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_dest(wb_dest),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct {
    bit       valid, regDst, jump, branch, memRead, memToReg, regWrite, ALUSrc, memWrite;
    bit [2:0] aluop;
    bit [4:0] rs, rt, rd;
  } instr_t;

  typedef struct {
    bit       valid, branch, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    bit [2:0] aluop;
    bit [4:0] rs, rt, dest;
  } slot_t;

  slot_t       pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  slot_t       bubble;
  instr_t      cur;
  bit          taken;
  bit          rst;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic instr_t nop();
    instr_t i = '{default: 0};
    return i;
  endfunction
  function automatic instr_t alu_rr(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
    instr_t i = '{default: 0};
    i.valid = 1; i.regDst = 1; i.regWrite = 1; i.aluop = 3'd2; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction
  function automatic instr_t alu_imm(input bit [4:0] rt, input bit [4:0] rs);
    instr_t i = '{default: 0};
    i.valid = 1; i.ALUSrc = 1; i.regWrite = 1; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic instr_t lw(input bit [4:0] rt, input bit [4:0] rs);
    instr_t i = alu_imm(rt, rs);
    i.memRead = 1; i.memToReg = 1;
    return i;
  endfunction
  function automatic instr_t beq(input bit [4:0] rs, input bit [4:0] rt);
    instr_t i = '{default: 0};
    i.valid = 1; i.branch = 1; i.aluop = 3'd1; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic instr_t rand_instr();
    instr_t i = '{default: 0};
    i.valid    = ($urandom_range(0, 99) < 85);
    i.regDst   = $urandom_range(0, 1) == 1;
    i.jump     = ($urandom_range(0, 99) < 5);
    i.branch   = !i.jump && ($urandom_range(0, 99) < 15);
    i.memRead  = !i.jump && !i.branch && ($urandom_range(0, 99) < 20);
    i.memWrite = !i.jump && !i.branch && !i.memRead && ($urandom_range(0, 99) < 10);
    i.memToReg = i.memRead;
    i.regWrite = !i.branch && !i.memWrite && ($urandom_range(0, 99) < 85);
    i.ALUSrc   = (i.memRead || i.memWrite) ? 1'b1 : ($urandom_range(0, 1) == 1);
    i.aluop    = 3'($urandom_range(0, 7));
    i.rs       = 5'($urandom_range(0, 7));
    i.rt       = 5'($urandom_range(0, 7));
    i.rd       = 5'($urandom_range(0, 7));
    return i;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit reads_rt(input instr_t i);
    return i.valid && (!i.ALUSrc || i.memWrite || i.branch);
  endfunction
  function automatic bit writes_reg(input slot_t s, input bit [4:0] r);
    return s.valid && s.reg_write && s.dest != 0 && s.dest == r;
  endfunction
  function automatic bit model_taken();
    return pipe[0].valid && pipe[0].branch && taken;
  endfunction
  function automatic bit model_stall();
    bit haz = 0;
    if (rst || model_taken() || !cur.valid) return 0;
`ifdef PIPE_CTRL_FWD_EN
    if (pipe[0].valid && pipe[0].mem_read && pipe[0].dest != 0)
      haz = (cur.rs == pipe[0].dest) || (reads_rt(cur) && cur.rt == pipe[0].dest);
`else
    for (int k = 0; k < 2; k++)
      haz = haz || writes_reg(pipe[k], cur.rs) || (reads_rt(cur) && writes_reg(pipe[k], cur.rt));
`endif
    return haz;
  endfunction
  function automatic bit model_flush();
    return !rst && (model_taken() || (cur.valid && cur.jump && !model_stall()));
  endfunction
  function automatic bit [1:0] model_fwd(input bit [4:0] r);
`ifdef PIPE_CTRL_FWD_EN
    if (writes_reg(pipe[1], r)) return 2'b10;
    if (writes_reg(pipe[2], r)) return 2'b01;
`endif
    return 2'b00;
  endfunction
  function automatic slot_t decode(input instr_t i);
    slot_t s;
    s.valid      = 1;
    s.branch     = i.branch;
    s.alu_src    = i.ALUSrc;
    s.mem_read   = i.memRead;
    s.mem_write  = i.memWrite;
    s.mem_to_reg = i.memToReg;
    s.aluop      = i.aluop;
    s.rs         = i.rs;
    s.rt         = i.rt;
    s.dest       = i.regDst ? i.rd : i.rt;
    s.reg_write  = i.regWrite && !i.jump && s.dest != 0;
    return s;
  endfunction

  task automatic apply();
    reset = rst;
    id_valid = cur.valid; id_regDst = cur.regDst; id_jump = cur.jump; id_branch = cur.branch;
    id_memRead = cur.memRead; id_memToReg = cur.memToReg; id_regWrite = cur.regWrite;
    id_ALUSrc = cur.ALUSrc; id_memWrite = cur.memWrite; id_ALUop = cur.aluop;
    id_rs = cur.rs; id_rt = cur.rt; id_rd = cur.rd; ex_branch_taken = taken;
  endtask

  task automatic check_outputs();
    check_eq("stall", 32'(stall), 32'(model_stall()));
    check_eq("flush_ifid", 32'(flush_ifid), 32'(model_flush()));
    check_eq("ex_valid", 32'(ex_valid), 32'(pipe[0].valid));
    check_eq("ex_branch", 32'(ex_branch), 32'(pipe[0].branch));
    check_eq("ex_ALUSrc", 32'(ex_ALUSrc), 32'(pipe[0].alu_src));
    check_eq("ex_memRead", 32'(ex_memRead), 32'(pipe[0].mem_read));
    check_eq("ex_ALUop", 32'(ex_ALUop), 32'(pipe[0].aluop));
    check_eq("ex_rs", 32'(ex_rs), 32'(pipe[0].rs));
    check_eq("ex_rt", 32'(ex_rt), 32'(pipe[0].rt));
    check_eq("mem_valid", 32'(mem_valid), 32'(pipe[1].valid));
    check_eq("mem_memRead", 32'(mem_memRead), 32'(pipe[1].mem_read));
    check_eq("mem_memWrite", 32'(mem_memWrite), 32'(pipe[1].mem_write));
    check_eq("wb_valid", 32'(wb_valid), 32'(pipe[2].valid));
    check_eq("wb_regWrite", 32'(wb_regWrite), 32'(pipe[2].reg_write));
    check_eq("wb_memToReg", 32'(wb_memToReg), 32'(pipe[2].mem_to_reg));
    check_eq("wb_dest", 32'(wb_dest), 32'(pipe[2].dest));
    check_eq("fwd_a", 32'(fwd_a), 32'(model_fwd(pipe[0].rs)));
    check_eq("fwd_b", 32'(fwd_b), 32'(model_fwd(pipe[0].rt)));
  endtask

  // One cycle: drive, check at negedge, advance model at posedge. Returns whether ID was held.
  task automatic do_cycle(output bit held);
    bit s, t;
    apply();
    @(negedge clk);
    check_outputs();
    s = model_stall();
    t = model_taken();
    held = s;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = bubble;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (cur.valid && !s && !t) ? decode(cur) : bubble;
    end
    #1;
  endtask

  task automatic run_prog(input instr_t prog[$], input bit tk);
    bit held;
    int guard = 0;
    taken = tk;
    while (prog.size() > 0) begin
      cur = prog[0];
      do_cycle(held);
      if (!held) void'(prog.pop_front());
      guard++;
      if (guard > 50) begin
        check_eq("prog_progress_timeout", 32'(prog.size()), 32'd0);
        prog.delete();
      end
    end
    cur = nop();
    for (int k = 0; k < 4; k++) do_cycle(held);
  endtask

  initial begin
    instr_t p[$];
    bit held;
    for (int k = 0; k < 3; k++) pipe[k] = bubble;
    rst = 1; taken = 0; cur = alu_rr(5'd3, 5'd1, 5'd2);
    apply();
    @(posedge clk); #1;
    // Reset held 2 cycles with a valid ID instruction, then release.
    for (int k = 0; k < 2; k++) do_cycle(held);
    rst = 0;
    do_cycle(held);
    cur = nop();
    do_cycle(held);
    check_eq("ex_valid_after_reset_release", 32'(wb_valid | mem_valid), 32'd1);

    p.delete(); p.push_back(alu_rr(5'd3, 5'd1, 5'd2)); p.push_back(alu_rr(5'd4, 5'd3, 5'd5));
    run_prog(p, 0);
    p.delete(); p.push_back(alu_rr(5'd3, 5'd1, 5'd2)); p.push_back(nop());
    p.push_back(alu_rr(5'd4, 5'd3, 5'd5));
    run_prog(p, 0);
    p.delete(); p.push_back(lw(5'd6, 5'd1)); p.push_back(alu_rr(5'd7, 5'd6, 5'd6));
    run_prog(p, 0);
    p.delete(); p.push_back(lw(5'd6, 5'd1)); p.push_back(beq(5'd1, 5'd2));
    p.push_back(alu_rr(5'd7, 5'd6, 5'd6));
    run_prog(p, 1);
    p.delete(); p.push_back(alu_imm(5'd0, 5'd1)); p.push_back(alu_rr(5'd2, 5'd0, 5'd0));
    run_prog(p, 0);

    // Randomized stream; ID held stable whenever the model says stall.
    held = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) cur = rand_instr();
      taken = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 99) == 0);
      do_cycle(held);
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
